// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, scan state encoding and the row-word helper
// for the 8x8 LED matrix row-scan controller.
//   ROWS, COLS : matrix geometry (fixed 8x8)
//   WORD_W     : width of the word handed to the cascaded 74HC595 serializer
//   scan_state_e : LOAD -> SEND -> WAIT_DONE -> DWELL
//   make_word  : builds {row one-hot, inverted column bits}
package matrix_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2,
    DWELL     = 2'd3
  } scan_state_e;

  // Row drivers are active-high one-hot; column sinks are active-low, so a
  // lit pixel (1) becomes a 0 on its column output.
  function automatic logic [WORD_W-1:0] make_word(input logic [2:0]      row,
                                                  input logic [COLS-1:0] pixels);
    logic [ROWS-1:0] onehot;
    onehot = {{(ROWS-1){1'b0}}, 1'b1} << row;
    return {onehot, ~pixels};
  endfunction

endpackage

// File: rtl/matrix_scan_scheduler_if.sv
// matrix_scan_scheduler_if: word handshake and output-enable between the
// row-scan scheduler (master) and the 16-bit 74HC595 serializer (slave).
//   word_valid/word_data/word_ready : valid/ready word transfer
//   shift_done                      : serializer has shifted and latched
//   oe_n                            : 74HC595 output enable, active low
interface matrix_scan_scheduler_if;
  import matrix_pkg::*;

  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;
  logic              shift_done;
  logic              oe_n;

  modport master (
    output word_valid,
    output word_data,
    output oe_n,
    input  word_ready,
    input  shift_done
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  oe_n,
    output word_ready,
    output shift_done
  );

endinterface

// File: rtl/matrix_frame_dbuf.sv
// matrix_frame_dbuf: double-buffered 8x8 frame store.
//   sys_clk, rst_n        : clock, async active-low reset (banks clear to 0)
//   wr_en/wr_row/wr_data  : host write into the bank that is currently back
//   swap                  : toggle which bank is front (frame boundary)
//   rd_row/rd_data        : combinational read of the front bank
module matrix_frame_dbuf
  import matrix_pkg::*;
(
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            swap,
  input  logic [2:0]      rd_row,
  output logic [COLS-1:0] rd_data
);

  logic [COLS-1:0] bank0_r [ROWS];
  logic [COLS-1:0] bank1_r [ROWS];
  logic            front_r;

  // Bank storage and front index. The write targets the bank that is back
  // before any swap this cycle, so a coincident write lands in the new front.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++) begin
        bank0_r[i] <= {COLS{1'b0}};
        bank1_r[i] <= {COLS{1'b0}};
      end
      front_r <= 1'b0;
    end else begin
      if (wr_en) begin
        if (front_r) begin
          bank0_r[wr_row] <= wr_data;
        end else begin
          bank1_r[wr_row] <= wr_data;
        end
      end
      if (swap) begin
        front_r <= ~front_r;
      end
    end
  end

  // Front-bank read port.
  always_comb begin
    rd_data = {COLS{1'b0}};
    if (front_r) begin
      rd_data = bank1_r[rd_row];
    end else begin
      rd_data = bank0_r[rd_row];
    end
  end

endmodule

// File: rtl/matrix_scan_scheduler.sv
// matrix_scan_scheduler: row-scan controller for an 8x8 LED matrix driven
// through two cascaded 74HC595s.
//   sys_clk, rst_n            : clock, async active-low reset
//   wr_en/wr_row/wr_data      : host writes one row into the back buffer
//   swap_req / swap_pending   : request front/back swap at next frame boundary
//   frame_start               : pulse in the cycle after row 0 is loaded
//   cur_row                   : row being loaded or displayed
//   ser (master)              : word_valid/word_data/word_ready, shift_done, oe_n
module matrix_scan_scheduler #(
  parameter int DWELL_CYCLES = 1024,
  parameter int ROWS         = 8,
  parameter int COLS         = 8
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_pending,
  output logic                    frame_start,
  output logic [$clog2(ROWS)-1:0] cur_row,
  matrix_scan_scheduler_if.master ser
);
  import matrix_pkg::*;

  localparam int                ROW_W      = $clog2(ROWS);
  localparam int                CNT_W      = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);

  scan_state_e       state_r;
  logic [CNT_W-1:0]  dwell_cnt_r;
  logic [ROW_W-1:0]  cur_row_r;
  logic              word_valid_r;
  logic [WORD_W-1:0] word_data_r;
  logic              frame_start_r;
  logic              swap_pending_r;
  logic              oe_n_r;
  logic [COLS-1:0]   front_pixels_s;
  logic              boundary_s;
  logic              do_swap_s;

  matrix_frame_dbuf u_dbuf (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .swap    (do_swap_s),
    .rd_row  (cur_row_r),
    .rd_data (front_pixels_s)
  );

  // Frame boundary: last dwell cycle of the last row.
  always_comb begin
    boundary_s = 1'b0;
    if ((state_r == DWELL) && (dwell_cnt_r == {CNT_W{1'b0}}) && (cur_row_r == LAST_ROW)) begin
      boundary_s = 1'b1;
    end else begin
      boundary_s = 1'b0;
    end
    do_swap_s = boundary_s & swap_pending_r;
  end

  // Scan FSM with registered handshake, blanking and dwell counter.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= LOAD;
      dwell_cnt_r   <= {CNT_W{1'b0}};
      cur_row_r     <= {ROW_W{1'b0}};
      word_valid_r  <= 1'b0;
      word_data_r   <= {WORD_W{1'b0}};
      frame_start_r <= 1'b0;
      oe_n_r        <= 1'b1;
    end else begin
      frame_start_r <= 1'b0;
      case (state_r)
        LOAD: begin
          word_data_r   <= make_word(cur_row_r, front_pixels_s);
          word_valid_r  <= 1'b1;
          frame_start_r <= (cur_row_r == {ROW_W{1'b0}});
          oe_n_r        <= 1'b1;
          state_r       <= SEND;
        end
        SEND: begin
          if (word_valid_r && ser.word_ready) begin
            word_valid_r <= 1'b0;
            state_r      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ser.shift_done) begin
            dwell_cnt_r <= DWELL_LAST;
            oe_n_r      <= 1'b0;
            state_r     <= DWELL;
          end
        end
        DWELL: begin
          if (dwell_cnt_r == {CNT_W{1'b0}}) begin
            oe_n_r    <= 1'b1;
            cur_row_r <= cur_row_r + {{(ROW_W-1){1'b0}}, 1'b1};
            state_r   <= LOAD;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          word_valid_r <= 1'b0;
          oe_n_r       <= 1'b1;
          state_r      <= LOAD;
        end
      endcase
    end
  end

  // Swap request latch; a request in the swap cycle re-arms for the next frame.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pending_r <= 1'b0;
    end else if (swap_req) begin
      swap_pending_r <= 1'b1;
    end else if (do_swap_s) begin
      swap_pending_r <= 1'b0;
    end else begin
      swap_pending_r <= swap_pending_r;
    end
  end

  assign ser.word_valid = word_valid_r;
  assign ser.word_data  = word_data_r;
  assign ser.oe_n       = oe_n_r;
  assign swap_pending   = swap_pending_r;
  assign frame_start    = frame_start_r;
  assign cur_row        = cur_row_r;

endmodule

// File: doc/matrix_scan_scheduler.md
Name: matrix_scan_scheduler

Overview:
Row-scan controller for the 8x8 LED matrix behind two cascaded 74HC595s. It holds a double-buffered 8x8 frame and writes to it from a host port, and it swaps buffers only at frame boundaries. For each row it builds a 16-bit word {row one-hot, inverted column bits} and hands it to the 16-bit serializer over a valid/ready handshake. After the latch it controls OE blanking and the per-row dwell time.

Parameters:
DWELL_CYCLES, 1024, sys_clk cycles the row is displayed (oe_n low) after latch; legal range >= 1
ROWS, 8, number of matrix rows (fixed 8; parameter for readability only)
COLS, 8, columns per row (fixed 8)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write one row into back buffer this cycle
wr_row  in  3  row index for write
wr_data  in  8  row pixels, bit c = column c, 1 = LED on
swap_req  in  1  pulse: request front/back swap at next frame boundary
swap_pending  out  1  swap requested, not yet performed
frame_start  out  1  one-cycle pulse when row 0 of a new frame is loaded
word_valid  out  1  word_data valid for serializer
word_data  out  16  {8'b1<<cur_row, ~row_pixels}; bit 0 shifted first
word_ready  in  1  serializer accepts word when word_valid & word_ready
shift_done  in  1  one-cycle pulse: serializer has shifted and latched the word
oe_n  out  1  74HC595 output enable, active low
cur_row  out  3  row currently being loaded or displayed

Behaviour:
- Async reset values: both buffers 0 (all LEDs off), front index 0, state LOAD, cur_row 0, oe_n 1, word_valid 0, word_data 0, frame_start 0, swap_pending 0, dwell counter 0.
- States: LOAD -> SEND -> WAIT_DONE -> DWELL -> LOAD.
- LOAD (1 cycle): register word_data from the front buffer row cur_row. Pulse frame_start if cur_row==0. Go to SEND.
- SEND: word_valid=1, word_data held stable. On word_valid & word_ready, drop word_valid next cycle and go to WAIT_DONE. Earliest word_valid is 1 cycle after LOAD.
- WAIT_DONE: oe_n=1. Stay until shift_done=1, then load dwell counter with DWELL_CYCLES-1 and go to DWELL.
- DWELL: oe_n=0 for exactly DWELL_CYCLES cycles, then oe_n=1 and go to LOAD. cur_row increments modulo 8; 7 wraps to 0.
- oe_n is 1 in every state except DWELL. The display is blanked while shifting.
- Frame boundary is the last DWELL cycle of row 7. If swap_pending=1 there, the front index toggles and swap_pending clears; the next LOAD reads the new front.
- swap_req sets swap_pending. swap_req while already pending has no extra effect.
- swap_req in the same cycle as a boundary swap: the swap happens, and swap_pending is set again for the next frame.
- wr_en writes the buffer that is back at the start of the cycle. A write coincident with a swap lands in the buffer becoming front.
- Writes never touch the front buffer, so the displayed frame never tears.
- word_ready outside SEND is ignored. shift_done outside WAIT_DONE is ignored.
- rst_n assertion mid-word drops word_valid and raises oe_n immediately (async). After release, scanning restarts at row 0 with blank buffers.
- Dwell counter width is $clog2(DWELL_CYCLES+1). No other arithmetic overflow is possible.

Decomposition:
- Package matrix_pkg: ROWS, COLS, WORD_W=16, scan state enum {LOAD, SEND, WAIT_DONE, DWELL}, and function make_word(row, pixels) returning {onehot(row), ~pixels}.
- One sub-module, matrix_frame_dbuf: two 8x8 banks, front index, back-bank write port, front-bank read port, swap input.
- The FSM, dwell counter and handshake stay in matrix_scan_scheduler.

Test Plan:
- Reset, wr_row=0/wr_data=8'hA5, swap_req, word_ready tied 1, shift_done 2 cycles after acceptance -> after the boundary, row-0 word_data=16'h015A and frame_start pulses.
- DWELL_CYCLES=4; count oe_n low cycles per row -> exactly 4; oe_n=1 throughout SEND and WAIT_DONE. Row order 0..7 then wraps to 0 with word_data[15:8]=8'h01.
- Hold word_ready=0 for 10 cycles in SEND -> word_valid stays 1 and word_data stays stable; no advance until the handshake.
- Assert swap_req during row 3 -> swap_pending=1 until the boundary. The new frame appears only at the next row-0 word, and swap_pending returns to 0.
- swap_req and wr_en (row 2, 8'hFF) coincident with the boundary swap -> the row-2 word of the new frame is 16'h0400, and swap_pending=1 afterwards.
- Assert rst_n low while in WAIT_DONE -> oe_n=1 and word_valid=0 within the same cycle. After release, the first word is 16'h01FF (blank row 0).
